uart_tx: RTL and testbench

Byte-wide UART transmitter that drives the PMOD serial TXD line. It is the output-side counterpart to the existing UART receive stage and consumes bytes from fabric logic (RAM block, loopback path, LED controller) over a valid/ready handshake. Frames are 8N1, LSB first. It uses a one-byte holding register plus a shift register so a second byte can be queued while the current frame is on the wire. New frames are gated by the host's active-low CTS#.

---
 rtl/uart_tx_pkg.sv | 14 +
 rtl/uart_baud_gen.sv | 35 +++
 rtl/uart_tx.sv | 133 +++++++++++++
 tb/tb_uart_tx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame geometry defaults and transmitter state encoding.
package uart_tx_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 104;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts CLKS_PER_BIT clocks and flags the last clock of each bit.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done_c
);

  localparam int unsigned     CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done_c = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register and CTS#-gated frame starts.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic                 cts,
  output logic                 tx,
  output logic                 busy
);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 ready_q, ready_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 bit_done_c;
  logic                 restart_c;
  logic                 start_ok_c;

  // Counter is parked at zero while idle so the start bit gets a full period.
  assign restart_c  = (state_q == ST_IDLE);
  assign start_ok_c = !ready_q && !cts;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart_c),
    .bit_done_c(bit_done_c)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    ready_d   = ready_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    if (data_valid && ready_q) begin
      hold_d  = data_in;
      ready_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start_ok_c) begin
          state_d = ST_START;
          shift_d = hold_q;
          ready_d = 1'b1;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done_c) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done_c) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_done_c) begin
          // Chain straight into the next start bit when a byte is waiting and CTS# allows.
          if (start_ok_c) begin
            state_d = ST_START;
            shift_d = hold_q;
            ready_d = 1'b1;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      shift_q   <= '0;
      bit_idx_q <= 3'd0;
      ready_q   <= 1'b1;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      ready_q   <= ready_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign data_ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes queue expected frames, a line monitor decodes tx.
module tb_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       cts = 1'b0;
  logic       data_ready;
  logic       tx;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         frames_done = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .cts       (cts),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor: one frame is 40 samples; the expected waveform is built from the byte alone.
  logic [39:0] samp;
  logic [39:0] exp_wave;
  logic [7:0]  eb;
  int          fstart;
  bit          aborted;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset && tx == 1'b0) begin
        fstart  = cyc;
        aborted = 1'b0;
        samp    = '0;
        for (int s = 0; s < int'(FRAME); s++) begin
          if (s > 0) @(negedge clk);
          if (!reset) begin
            aborted = 1'b1;
            break;
          end
          samp[s] = tx;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 64'(samp), 64'd0);
          end else begin
            eb = exp_q.pop_front();
            for (int s = 0; s < int'(FRAME); s++) begin
              int slot;
              slot = s / int'(CPB);
              if (slot == 0)      exp_wave[s] = 1'b0;
              else if (slot == 9) exp_wave[s] = 1'b1;
              else                exp_wave[s] = eb[slot-1];
            end
            check("frame_wave", 64'(samp), 64'(exp_wave));
          end
          start_q.push_back(fstart);
          frames_done++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    data_in    = b;
    data_valid = 1'b1;
    while (!data_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready) begin
      check("send_timeout", 64'd0, 64'd1);
      data_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk);
      exp_q.push_back(b);
      @(negedge clk);
      acc        = cyc;
      data_valid = 1'b0;
      data_in    = 8'($urandom);
    end
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(frames_done), 64'(target));
  endtask

  task automatic wait_until_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int acc, acc2, c0, base, cnt;

    // Reset and idle line
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(data_ready), 64'd1);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) cnt++;
    end
    check("idle_no_toggle", 64'(cnt), 64'd0);

    // Single byte: latency and busy width
    base = frames_done;
    send(8'hA5, acc);
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("busy_cycles", 64'(cnt), 64'(FRAME));
    check("ready_after_frame", 64'(data_ready), 64'd1);
    wait_frames(base + 1, 100, "single_frame_done");
    if (start_q.size() > 0) check("start_latency", 64'(start_q[$] - acc), 64'd1);

    // Back-to-back with a byte queued mid-frame; junk offered while full is ignored
    base = frames_done;
    send(8'h55, acc);
    wait_until_cyc(acc + 8);
    send(8'h0F, acc2);
    check("ready_low_while_held", 64'(data_ready), 64'd0);
    data_in    = 8'hEE;
    data_valid = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (data_ready) cnt++;
    end
    data_valid = 1'b0;
    check("ready_stays_low", 64'(cnt), 64'd0);
    wait_frames(base + 2, 200, "b2b_frames_done");
    if (start_q.size() >= 2)
      check("b2b_gap", 64'(start_q[start_q.size()-1] - start_q[start_q.size()-2]), 64'(FRAME));

    // Flow control: byte held while CTS# is high
    @(negedge clk);
    cts  = 1'b1;
    base = frames_done;
    send(8'h3C, acc);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || data_ready || busy) cnt++;
    end
    check("cts_hold_quiet", 64'(cnt), 64'd0);
    cts = 1'b0;
    c0  = cyc;
    wait_frames(base + 1, 100, "cts_release_frame");
    if (start_q.size() > 0) check("cts_release_latency", 64'(start_q[$] - c0), 64'd1);

    // CTS# raised mid-frame: current frame completes, queued one waits
    base = frames_done;
    send(8'hFF, acc);
    send(8'h12, acc2);
    wait_until_cyc(acc + 19);
    cts = 1'b1;
    wait_until_cyc(acc + 80);
    check("midcts_one_frame", 64'(frames_done), 64'(base + 1));
    check("midcts_tx_idle", 64'(tx), 64'd1);
    check("midcts_busy", 64'(busy), 64'd0);
    check("midcts_ready", 64'(data_ready), 64'd0);
    cts = 1'b0;
    c0  = cyc;
    wait_frames(base + 2, 100, "midcts_second_frame");
    if (start_q.size() > 0) check("midcts_release_latency", 64'(start_q[$] - c0), 64'd1);

    // Reset during data bit 4 discards both the frame and the queued byte
    send(8'h66, acc);
    send(8'h42, acc2);
    wait_until_cyc(acc + 22);
    check("bit4_before_reset", 64'(tx), 64'd0);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_tx", 64'(tx), 64'd1);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_ready", 64'(data_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    base  = frames_done;
    cnt   = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) cnt++;
    end
    check("post_reset_quiet", 64'(cnt), 64'd0);
    check("post_reset_no_frame", 64'(frames_done), 64'(base));
    send(8'h81, acc);
    wait_frames(base + 1, 100, "post_reset_frame");

    // Randomized traffic with random gaps and CTS# pauses
    base = frames_done;
    for (int i = 0; i < 24; i++) begin
      send(8'($urandom), acc);
      cts = ($urandom_range(3) == 0);
      repeat ($urandom_range(50)) @(negedge clk);
      cts = 1'b0;
    end
    wait_frames(base + 24, 400, "random_frames_done");
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
